// File: rtl/conv_stream_driver.sv
// conv_stream_driver: holds one IFM frame and one kernel written by the host, replays them as a
//   registered in_valid/In_IFM/In_Weight burst into the convolution engine, then captures results.
// Latency: start (in IDLE) -> first beat on the next edge; beats run back to back with no bubbles.
// Backpressure: none; the engine must accept every beat. Results beyond N_RESULT are dropped and flagged.
//
// Ports: clk/rst_n (async active-low); cfg_we/cfg_sel/cfg_addr/cfg_wdata host write port;
//   start/busy/done frame control; in_valid/In_IFM/In_Weight stream to the engine;
//   out_valid/Out_OFM results from the engine; res_addr/res_data combinational result readback;
//   res_cnt, err_timeout, err_ovf status; res_chksum XOR of captured results.
// Optional feature macro: CONV_DRV_CHKSUM_EN (undefined -> res_chksum is tied to zero).
module conv_stream_driver #(
    parameter int IMG_PIXELS = 196,
    parameter int N_WEIGHT   = 9,
    parameter int N_RESULT   = 36,
    parameter int TIMEOUT    = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_we,
    input  logic        cfg_sel,
    input  logic [7:0]  cfg_addr,
    input  logic [15:0] cfg_wdata,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        in_valid,
    output logic [15:0] In_IFM,
    output logic [15:0] In_Weight,
    input  logic        out_valid,
    input  logic [35:0] Out_OFM,
    input  logic [5:0]  res_addr,
    output logic [35:0] res_data,
    output logic [5:0]  res_cnt,
    output logic        err_timeout,
    output logic        err_ovf,
    output logic [35:0] res_chksum
);
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [7:0]         beat_q, beat_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [5:0]         res_cnt_q, res_cnt_d;
    logic               in_valid_q, in_valid_d;
    logic [15:0]        in_ifm_q, in_ifm_d;
    logic [15:0]        in_weight_q, in_weight_d;
    logic               done_q, done_d;
    logic               err_timeout_q, err_timeout_d;
    logic               err_ovf_q, err_ovf_d;

    logic [15:0]        ifm_mem_q [IMG_PIXELS];
    logic [15:0]        w_mem_q   [N_WEIGHT];
    logic [35:0]        res_mem_q [N_RESULT];

    logic               busy_w;
    logic               ifm_we;
    logic               w_we;
    logic               res_we;
    logic               has_room;
    logic               frame_clr;
    logic [15:0]        ifm_first;
    logic [15:0]        w_first;

    assign busy_w    = (state_q == S_SEND) || (state_q == S_WAIT);
    assign has_room  = int'(res_cnt_q) < N_RESULT;
    assign frame_clr = (state_q == S_IDLE) && start;

    // Host writes are locked out for the whole frame so the replayed data cannot change under it.
    assign ifm_we = cfg_we && !busy_w && !cfg_sel && (int'(cfg_addr) < IMG_PIXELS);
    assign w_we   = cfg_we && !busy_w &&  cfg_sel && (int'(cfg_addr) < N_WEIGHT);

    // Beat 0 is launched on the same edge a write may land, so forward the write data.
    assign ifm_first = (ifm_we && cfg_addr == 8'd0) ? cfg_wdata : ifm_mem_q[0];
    assign w_first   = (w_we   && cfg_addr == 8'd0) ? cfg_wdata : w_mem_q[0];

    always_comb begin
        state_d       = state_q;
        beat_d        = beat_q;
        tmo_d         = tmo_q;
        res_cnt_d     = res_cnt_q;
        err_timeout_d = err_timeout_q;
        err_ovf_d     = err_ovf_q;
        done_d        = 1'b0;
        in_valid_d    = 1'b0;
        in_ifm_d      = '0;
        in_weight_d   = '0;
        res_we        = 1'b0;

        // Results are accepted during SEND as well as WAIT; a slow burst must not lose early results.
        if (busy_w && out_valid) begin
            if (has_room) begin
                res_we    = 1'b1;
                res_cnt_d = res_cnt_q + 6'd1;
            end else begin
                err_ovf_d = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d       = S_SEND;
                    beat_d        = 8'd1;
                    tmo_d         = '0;
                    res_cnt_d     = '0;
                    err_timeout_d = 1'b0;
                    err_ovf_d     = 1'b0;
                    in_valid_d    = 1'b1;
                    in_ifm_d      = ifm_first;
                    in_weight_d   = w_first;
                end
            end
            S_SEND: begin
                in_valid_d = 1'b1;
                in_ifm_d   = ifm_mem_q[beat_q];
                if (int'(beat_q) < N_WEIGHT) begin
                    in_weight_d = w_mem_q[beat_q[3:0]];
                end
                beat_d = beat_q + 8'd1;
                tmo_d  = '0;
                if (int'(beat_q) == IMG_PIXELS - 1) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!has_room) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else if (res_we) begin
                    tmo_d = '0;
                end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    err_timeout_d = 1'b1;
                    state_d       = S_DONE;
                    done_d        = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            beat_q        <= '0;
            tmo_q         <= '0;
            res_cnt_q     <= '0;
            in_valid_q    <= 1'b0;
            in_ifm_q      <= '0;
            in_weight_q   <= '0;
            done_q        <= 1'b0;
            err_timeout_q <= 1'b0;
            err_ovf_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            beat_q        <= beat_d;
            tmo_q         <= tmo_d;
            res_cnt_q     <= res_cnt_d;
            in_valid_q    <= in_valid_d;
            in_ifm_q      <= in_ifm_d;
            in_weight_q   <= in_weight_d;
            done_q        <= done_d;
            err_timeout_q <= err_timeout_d;
            err_ovf_q     <= err_ovf_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < IMG_PIXELS; i++) ifm_mem_q[i] <= '0;
            for (int i = 0; i < N_WEIGHT; i++)   w_mem_q[i]   <= '0;
            for (int i = 0; i < N_RESULT; i++)   res_mem_q[i] <= '0;
        end else begin
            if (ifm_we) ifm_mem_q[cfg_addr]    <= cfg_wdata;
            if (w_we)   w_mem_q[cfg_addr[3:0]] <= cfg_wdata;
            if (res_we) res_mem_q[res_cnt_q]   <= Out_OFM;
        end
    end

`ifdef CONV_DRV_CHKSUM_EN
    logic [35:0] chk_q, chk_d;

    always_comb begin
        chk_d = chk_q;
        if (frame_clr) begin
            chk_d = '0;
        end else if (res_we) begin
            chk_d = chk_q ^ Out_OFM;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_q <= '0;
        end else begin
            chk_q <= chk_d;
        end
    end

    assign res_chksum = chk_q;
`else
    assign res_chksum = 36'd0;
`endif

    assign busy        = busy_w;
    assign done        = done_q;
    assign in_valid    = in_valid_q;
    assign In_IFM      = in_ifm_q;
    assign In_Weight   = in_weight_q;
    assign res_cnt     = res_cnt_q;
    assign err_timeout = err_timeout_q;
    assign err_ovf     = err_ovf_q;
    assign res_data    = (int'(res_addr) < N_RESULT) ? res_mem_q[res_addr] : 36'd0;

endmodule

// File: tb/tb_conv_stream_driver.sv
`timescale 1ns/1ps
module tb_conv_stream_driver;
    localparam int IMG_PIXELS = 196;
    localparam int N_WEIGHT   = 9;
    localparam int N_RESULT   = 36;
    localparam int TIMEOUT    = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_we = 1'b0;
    logic        cfg_sel = 1'b0;
    logic [7:0]  cfg_addr = '0;
    logic [15:0] cfg_wdata = '0;
    logic        start = 1'b0;
    logic        busy, done, in_valid;
    logic [15:0] In_IFM, In_Weight;
    logic        out_valid = 1'b0;
    logic [35:0] Out_OFM = '0;
    logic [5:0]  res_addr = '0;
    logic [35:0] res_data;
    logic [5:0]  res_cnt;
    logic        err_timeout, err_ovf;
    logic [35:0] res_chksum;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    conv_stream_driver dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .start(start), .busy(busy), .done(done),
        .in_valid(in_valid), .In_IFM(In_IFM), .In_Weight(In_Weight),
        .out_valid(out_valid), .Out_OFM(Out_OFM),
        .res_addr(res_addr), .res_data(res_data), .res_cnt(res_cnt),
        .err_timeout(err_timeout), .err_ovf(err_ovf), .res_chksum(res_chksum)
    );

    // Reference contents of the host-visible arrays and the results the engine model returned.
    logic [15:0] ifm_ref [IMG_PIXELS];
    logic [15:0] w_ref   [N_WEIGHT];
    logic [35:0] res_ref [$];

    // Stream observer.
    logic [15:0] mon_ifm [$];
    logic [15:0] mon_w   [$];
    int   cyc = 0, runs = 0, done_cnt = 0, busy_viol = 0, zero_viol = 0, tmo_cyc = -1;
    logic prev_vld = 1'b0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (in_valid) begin
            mon_ifm.push_back(In_IFM);
            mon_w.push_back(In_Weight);
            if (!busy) busy_viol++;
        end else if (In_IFM != 16'h0 || In_Weight != 16'h0) begin
            zero_viol++;
        end
        if (in_valid && !prev_vld) runs++;
        prev_vld = in_valid;
        if (done) done_cnt++;
        if (err_timeout && tmo_cyc < 0) tmo_cyc = cyc;
    end

    task automatic cfg_write(input logic sel, input int addr, input logic [15:0] data);
        cfg_we = 1'b1; cfg_sel = sel; cfg_addr = addr[7:0]; cfg_wdata = data;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic load_frame(input bit ramp);
        for (int k = 0; k < IMG_PIXELS; k++) begin
            ifm_ref[k] = ramp ? 16'(k) : 16'($urandom);
            cfg_write(1'b0, k, ifm_ref[k]);
        end
        for (int k = 0; k < N_WEIGHT; k++) begin
            w_ref[k] = ramp ? 16'(k + 1) : 16'($urandom);
            cfg_write(1'b1, k, w_ref[k]);
        end
        // Out-of-range addresses are dropped; 0x12 would alias weight 2 if the range were ignored.
        cfg_write(1'b0, 255, 16'hDEAD);
        cfg_write(1'b1, 8'h12, 16'hBEEF);
    endtask

    // Launches one frame, plays the engine (nres results after the burst), and checks the stream,
    // the completion handshake and the captured results against the reference.
    task automatic run_frame(input string tag, input int nres, input bit fixed_pat,
                             input bit co_write, input bit poke, output int last_cyc);
        int guard, runs0, done0, exp_cnt;
        logic [35:0] v, exp_x, exp_chk;
        logic [15:0] exp_w;
        exp_x = '0;
        last_cyc = cyc;
        mon_ifm.delete(); mon_w.delete(); res_ref.delete();
        runs0 = runs; done0 = done_cnt;
        start = 1'b1;
        if (co_write) begin
            ifm_ref[0] = 16'($urandom);
            cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = 8'd0; cfg_wdata = ifm_ref[0];
        end
        @(negedge clk);
        start = 1'b0; cfg_we = 1'b0; tmo_cyc = -1;
        checks++;
        if (in_valid !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL %s start_latency: in_valid=%0b busy=%0b expected 1 1", tag, in_valid, busy);
        end
        if (poke) begin
            guard = 0;
            while (mon_ifm.size() < 20 && guard < 100) begin @(negedge clk); guard++; end
            start = 1'b1; cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = 8'd5; cfg_wdata = ~ifm_ref[5];
            @(negedge clk);
            cfg_sel = 1'b1; cfg_addr = 8'd2; cfg_wdata = ~w_ref[2];
            @(negedge clk);
            start = 1'b0; cfg_we = 1'b0;
        end
        guard = 0;
        while (in_valid === 1'b1 && guard < 400) begin @(negedge clk); guard++; end
        checks++;
        if (guard >= 400) begin
            failures++;
            $display("FAIL %s burst_end: in_valid still %0b after %0d cycles, expected 0", tag, in_valid, guard);
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < nres; i++) begin
            v = fixed_pat ? (36'hA000000 + 36'(i)) : 36'({$urandom, $urandom});
            if (i < N_RESULT) begin
                res_ref.push_back(v);
                exp_x ^= v;
            end
            out_valid = 1'b1; Out_OFM = v;
            last_cyc = cyc;
            @(negedge clk);
        end
        out_valid = 1'b0; Out_OFM = '0;
        guard = 0;
        while (busy === 1'b1 && guard < TIMEOUT + 200) begin @(negedge clk); guard++; end
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL %s completion: busy=%0b expected 0", tag, busy);
        end
        checks++;
        if (mon_ifm.size() != IMG_PIXELS) begin
            failures++;
            $display("FAIL %s beat_count: got %0d expected %0d", tag, mon_ifm.size(), IMG_PIXELS);
        end
        for (int k = 0; k < IMG_PIXELS && k < mon_ifm.size(); k++) begin
            exp_w = (k < N_WEIGHT) ? w_ref[k] : 16'h0;
            checks++;
            if (mon_ifm[k] !== ifm_ref[k] || mon_w[k] !== exp_w) begin
                failures++;
                $display("FAIL %s beat[%0d]: ifm=%0h w=%0h expected ifm=%0h w=%0h",
                         tag, k, mon_ifm[k], mon_w[k], ifm_ref[k], exp_w);
            end
        end
        checks++;
        if (runs - runs0 != 1 || busy_viol != 0 || zero_viol != 0) begin
            failures++;
            $display("FAIL %s burst_shape: runs=%0d busy_viol=%0d zero_viol=%0d expected 1 0 0",
                     tag, runs - runs0, busy_viol, zero_viol);
        end
        checks++;
        if (done_cnt - done0 != 1) begin
            failures++;
            $display("FAIL %s done_pulse: got %0d cycles expected 1", tag, done_cnt - done0);
        end
        exp_cnt = (nres < N_RESULT) ? nres : N_RESULT;
        checks++;
        if (int'(res_cnt) != exp_cnt) begin
            failures++;
            $display("FAIL %s res_cnt: got %0d expected %0d", tag, res_cnt, exp_cnt);
        end
        for (int i = 0; i < exp_cnt; i++) begin
            res_addr = 6'(i);
            #1;
            checks++;
            if (res_data !== res_ref[i]) begin
                failures++;
                $display("FAIL %s res_data[%0d]: got %0h expected %0h", tag, i, res_data, res_ref[i]);
            end
        end
`ifdef CONV_DRV_CHKSUM_EN
        exp_chk = exp_x;
`else
        exp_chk = 36'd0;
`endif
        checks++;
        if (res_chksum !== exp_chk) begin
            failures++;
            $display("FAIL %s chksum: got %0h expected %0h", tag, res_chksum, exp_chk);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        int runs0;
        #3;
        checks++;
        if ({busy, done, in_valid, err_timeout, err_ovf} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got %05b expected 00000", {busy, done, in_valid, err_timeout, err_ovf});
        end
        checks++;
        if (In_IFM !== 16'h0 || In_Weight !== 16'h0) begin
            failures++;
            $display("FAIL reset_stream: ifm=%0h w=%0h expected 0 0", In_IFM, In_Weight);
        end
        checks++;
        if (res_cnt !== 6'd0 || res_data !== 36'd0 || res_chksum !== 36'd0) begin
            failures++;
            $display("FAIL reset_results: cnt=%0d data=%0h chk=%0h expected 0", res_cnt, res_data, res_chksum);
        end
        @(negedge clk);
        rst_n = 1'b1;
        runs0 = runs;
        repeat (500) @(negedge clk);
        checks++;
        if (runs != runs0 || in_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: runs=%0d in_valid=%0b busy=%0b expected 0 0 0", runs - runs0, in_valid, busy);
        end
    endtask

    task automatic test_burst();
        int lc;
        load_frame(1'b1);
        run_frame("burst", N_RESULT, 1'b0, 1'b0, 1'b0, lc);
    endtask

    task automatic test_capture();
        int lc;
        load_frame(1'b0);
        // Write IFM[0] in the start cycle: the frame must replay the new value.
        run_frame("capture", N_RESULT, 1'b1, 1'b1, 1'b0, lc);
        res_addr = 6'd35; #1;
        checks++;
        if (res_data !== 36'hA000023) begin
            failures++;
            $display("FAIL capture_last: got %0h expected a000023", res_data);
        end
        res_addr = 6'd36; #1;
        checks++;
        if (res_data !== 36'd0) begin
            failures++;
            $display("FAIL capture_addr36: got %0h expected 0", res_data);
        end
        res_addr = 6'd63; #1;
        checks++;
        if (res_data !== 36'd0) begin
            failures++;
            $display("FAIL capture_addr63: got %0h expected 0", res_data);
        end
        checks++;
        if (err_timeout !== 1'b0 || err_ovf !== 1'b0) begin
            failures++;
            $display("FAIL capture_flags: tmo=%0b ovf=%0b expected 0 0", err_timeout, err_ovf);
        end
    endtask

    task automatic test_timeout();
        int lc;
        run_frame("timeout", 10, 1'b0, 1'b0, 1'b0, lc);
        checks++;
        if (err_timeout !== 1'b1 || err_ovf !== 1'b0) begin
            failures++;
            $display("FAIL timeout_flags: tmo=%0b ovf=%0b expected 1 0", err_timeout, err_ovf);
        end
        // The 10th result is taken on the rising edge after it is driven; the timer expires
        // TIMEOUT edges later and is visible at the following falling edge.
        checks++;
        if (tmo_cyc - lc != TIMEOUT + 1) begin
            failures++;
            $display("FAIL timeout_latency: got %0d expected %0d", tmo_cyc - lc, TIMEOUT + 1);
        end
    endtask

    task automatic test_overflow_guards();
        int lc;
        // Writes and a start pulse while the burst runs must be ignored; the reference stays put.
        run_frame("overflow", N_RESULT + 1, 1'b0, 1'b0, 1'b1, lc);
        checks++;
        if (err_ovf !== 1'b1 || err_timeout !== 1'b0) begin
            failures++;
            $display("FAIL overflow_flags: ovf=%0b tmo=%0b expected 1 0", err_ovf, err_timeout);
        end
        run_frame("after_guard", N_RESULT, 1'b0, 1'b0, 1'b0, lc);
        checks++;
        if (err_ovf !== 1'b0 || err_timeout !== 1'b0) begin
            failures++;
            $display("FAIL after_guard_flags: ovf=%0b tmo=%0b expected 0 0", err_ovf, err_timeout);
        end
    endtask

    task automatic test_reset_mid_frame();
        int guard, lc;
        load_frame(1'b0);
        mon_ifm.delete(); mon_w.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (mon_ifm.size() < 50 && guard < 300) begin @(negedge clk); guard++; end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (in_valid !== 1'b0 || busy !== 1'b0 || In_IFM !== 16'h0) begin
            failures++;
            $display("FAIL midreset_drop: in_valid=%0b busy=%0b ifm=%0h expected 0 0 0", in_valid, busy, In_IFM);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (res_cnt !== 6'd0 || in_valid !== 1'b0) begin
            failures++;
            $display("FAIL midreset_idle: res_cnt=%0d in_valid=%0b expected 0 0", res_cnt, in_valid);
        end
        // Reset clears both arrays, so the next frame replays zeros for all 196 beats.
        for (int k = 0; k < IMG_PIXELS; k++) ifm_ref[k] = 16'h0;
        for (int k = 0; k < N_WEIGHT; k++)   w_ref[k]   = 16'h0;
        run_frame("after_reset", N_RESULT, 1'b0, 1'b0, 1'b0, lc);
    endtask

    initial begin
        test_reset();
        test_burst();
        test_capture();
        test_timeout();
        test_overflow_guards();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
